// File: rtl/fir_out_decimator.sv
// Decimator and FWFT FIFO placed after fir_filter: keeps every DECIM-th valid
// sample, buffers it in a DEPTH-entry FIFO and reports dropped kept samples.
module fir_out_decimator #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int              PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(DECIM - 1);
  localparam logic [ADDR_W:0] FULL_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic kept, pop, full, push, drop;

  // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
  always_comb begin
    kept = in_valid && (phase_q == '0);
    full = (count_q == FULL_C);
    pop  = out_valid && out_ready;
    push = kept && (!full || pop);
    drop = kept && full && !pop;

    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PH_MAX) ? '0 : phase_q + PH_W'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator with hand-computed expectations
// (DECIM=4, DEPTH=8).
module tb_fir_out_decimator;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clr_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  count;
  logic        overflow;

  int vectors;
  int miscompares;

  fir_out_decimator #(.DATA_W(16), .DECIM(4), .DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 16'hABCD; clr_ovf = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234; clr_ovf = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid cyc%0d got %b exp 0", c, out_valid); end
      vectors++;
      if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count cyc%0d got %0d exp 0", c, count); end
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow cyc%0d got %b exp 0", c, overflow); end
      vectors++;
      if (out_data !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_out_data cyc%0d got %0d exp 0", c, out_data); end
    end
    reset = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_decimate();
    logic        ev;
    logic [15:0] ed;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
      ev = ((i - 1) % 4 == 0);
      ed = ev ? 16'(i) : 16'd0;
      vectors++;
      if (out_valid !== ev || out_data !== ed) begin
        miscompares++;
        $display("[TB] FAIL decimate_s%0d got v=%b d=%0d exp v=%b d=%0d", i, out_valid, out_data, ev, ed);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL decimate_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_idle_gaps();
    logic [15:0] seen [$];
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 16'(k);
      tick();
      if (out_valid) seen.push_back(out_data);
      in_valid = 1'b0;
      tick();
      if (out_valid) seen.push_back(out_data);
    end
    tick(); tick();
    vectors++;
    if (seen.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL idle_gap_count got %0d exp 2", seen.size());
    end else begin
      vectors++;
      if (seen[0] !== 16'd1) begin miscompares++; $display("[TB] FAIL idle_gap_first got %0d exp 1", seen[0]); end
      vectors++;
      if (seen[1] !== 16'd5) begin miscompares++; $display("[TB] FAIL idle_gap_second got %0d exp 5", seen[1]); end
    end
  endtask

  task automatic test_overflow_drain();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (count !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_full_count got %0d exp 8", count); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got %b exp 1", overflow); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'd1) begin
      miscompares++; $display("[TB] FAIL ovf_hold got v=%b d=%0d exp v=1 d=1", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 16'(1 + 4 * j)) begin
        miscompares++;
        $display("[TB] FAIL ovf_drain_%0d got v=%b d=%0d exp v=1 d=%0d", j, out_valid, out_data, 1 + 4 * j);
      end
      tick();
    end
    vectors++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ovf_empty got count=%0d v=%b exp count=0 v=0", count, out_valid);
    end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky got %b exp 1", overflow); end
    tick();
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL ovf_no_underflow got %0d exp 0", count); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_q [$];
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fpp_fill got count=%0d ovf=%b exp count=8 ovf=0", count, overflow);
    end
    in_valid = 1'b1; in_data = 16'd99; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fpp_same_cycle got count=%0d ovf=%b exp count=8 ovf=0", count, overflow);
    end
    for (int j = 1; j < 8; j++) exp_q.push_back(16'(1 + 4 * j));
    exp_q.push_back(16'd99);
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_q[j]) begin
        miscompares++;
        $display("[TB] FAIL fpp_drain_%0d got v=%b d=%0d exp v=1 d=%0d", j, out_valid, out_data, exp_q[j]);
      end
      tick();
    end
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL fpp_empty got %0d exp 0", count); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    vectors++;
    if (count !== 4'd5) begin miscompares++; $display("[TB] FAIL mid_count got %0d exp 5", count); end
    reset = 1'b0; in_valid = 1'b1; in_data = 16'd19;
    tick();
    reset = 1'b1;
    vectors++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_reset got count=%0d v=%b exp count=0 v=0", count, out_valid);
    end
    in_valid = 1'b1; in_data = 16'd50;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'd50 || count !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL mid_first_kept got v=%b d=%0d count=%0d exp v=1 d=50 count=1", out_valid, out_data, count);
    end
  endtask

  task automatic test_clr_ovf();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    in_valid = 1'b1; in_data = 16'd77; clr_ovf = 1'b1;
    tick();
    vectors++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      miscompares++; $display("[TB] FAIL clr_set_wins got ovf=%b count=%0d exp ovf=1 count=8", overflow, count);
    end
    in_valid = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_alone got %b exp 0", overflow); end
    vectors++;
    if (out_data !== 16'd1) begin miscompares++; $display("[TB] FAIL clr_head got %0d exp 1", out_data); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; clr_ovf = 1'b0; out_ready = 1'b0;
    test_reset();
    test_decimate();
    test_idle_gaps();
    test_overflow_drain();
    test_full_push_pop();
    test_midstream_reset();
    test_clr_ovf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
